// File: rtl/pipeline_pkg.sv
// Shared pipeline constants and the memory-stage state encoding.
package pipeline_pkg;

  localparam int unsigned REG_SEL_W = 3;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned STATE_W   = 3;
  localparam int unsigned CNT_W     = 8;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } memState_t;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Clear/increment cycle counter that flags expiry once it reaches TIMEOUT-1.
module mem_timeout_cnt
  import pipeline_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      count <= '0;
    else if (clr) count <= '0;
    else if (inc) count <= count + CNT_W'(1);
  end

  // Only meaningful while the access is outstanding.
  assign expired = inc && (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage sequencer: drives the request/ready/done handshake, stalls
// upstream while an access is outstanding and presents results to M/W.
module mem_stage_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned TIMEOUT     = 64,
  parameter int unsigned ALIGN_CHECK = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_IN,
  input  logic                 memRead_IN,
  input  logic                 memWrite_IN,
  input  logic [DATA_W-1:0]    addr_IN,
  input  logic [DATA_W-1:0]    storeData_IN,
  input  logic                 writeEn_IN,
  input  logic [REG_SEL_W-1:0] writeRegSel_IN,
  input  logic                 HaltSel_IN,
  input  logic                 mem_ready,
  input  logic                 mem_done,
  input  logic [DATA_W-1:0]    mem_rdata,
  output logic                 mem_req,
  output logic                 mem_wr,
  output logic [DATA_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  output logic                 stall_OUT,
  output logic                 writeEn_OUT,
  output logic                 memRead_OUT,
  output logic [REG_SEL_W-1:0] writeRegSel_OUT,
  output logic [DATA_W-1:0]    writeRegData_OUT,
  output logic [DATA_W-1:0]    memDataOut_OUT,
  output logic                 HaltSel_OUT,
  output logic                 err_OUT
);

  memState_t          state, nextState;
  logic               memop, misalign, expired;
  logic               reqIssue, captureEn;
  logic [DATA_W-1:0]  holdData;

  assign memop    = valid_IN & (memRead_IN | memWrite_IN);
  assign misalign = (ALIGN_CHECK != 0) && addr_IN[0];

  mem_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeoutCnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (state == IDLE),
    .inc     ((state == REQ) || (state == WAIT)),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            holdData <= '0;
    else if (captureEn) holdData <= mem_rdata;
  end

  // Outputs are forced low while rst is held, not just after the next edge.
  always_comb begin
    nextState        = state;
    reqIssue         = 1'b0;
    captureEn        = 1'b0;
    mem_req          = 1'b0;
    mem_wr           = 1'b0;
    mem_addr         = '0;
    mem_wdata        = '0;
    stall_OUT        = 1'b0;
    writeEn_OUT      = 1'b0;
    memRead_OUT      = 1'b0;
    writeRegSel_OUT  = '0;
    writeRegData_OUT = '0;
    memDataOut_OUT   = '0;
    HaltSel_OUT      = 1'b0;
    err_OUT          = 1'b0;

    if (!rst) begin
      writeRegSel_OUT  = writeRegSel_IN;
      writeRegData_OUT = addr_IN;

      case (state)
        IDLE: begin
          if (memop) begin
            stall_OUT = 1'b1;
            if (misalign) begin
              nextState = ERR;
            end else begin
              reqIssue  = 1'b1;
              nextState = mem_ready ? WAIT : REQ;
            end
          end else begin
            writeEn_OUT = valid_IN & writeEn_IN;
            HaltSel_OUT = valid_IN & HaltSel_IN;
          end
        end
        REQ: begin
          stall_OUT = memop;
          reqIssue  = 1'b1;
          if (mem_ready)    nextState = WAIT;
          else if (expired) nextState = ERR;
        end
        WAIT: begin
          stall_OUT = memop;
          // A completion on the expiry cycle still counts as success.
          if (mem_done) begin
            nextState = DONE;
            captureEn = ~memWrite_IN;
          end else if (expired) begin
            nextState = ERR;
          end
        end
        DONE: begin
          writeEn_OUT    = valid_IN & writeEn_IN;
          memRead_OUT    = memRead_IN;
          memDataOut_OUT = holdData;
          HaltSel_OUT    = valid_IN & HaltSel_IN;
          nextState      = IDLE;
        end
        ERR: begin
          stall_OUT   = 1'b1;
          err_OUT     = 1'b1;
          HaltSel_OUT = 1'b1;
        end
        default: nextState = IDLE;
      endcase

      if (reqIssue) begin
        mem_req   = 1'b1;
        mem_wr    = memWrite_IN;
        mem_addr  = addr_IN;
        mem_wdata = storeData_IN;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl with hand-computed expectations (TIMEOUT=4).
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_IN, memRead_IN, memWrite_IN, writeEn_IN, HaltSel_IN;
  logic [15:0] addr_IN, storeData_IN;
  logic [2:0]  writeRegSel_IN;
  logic        mem_ready, mem_done;
  logic [15:0] mem_rdata;
  logic        mem_req, mem_wr, stall_OUT, writeEn_OUT, memRead_OUT, HaltSel_OUT, err_OUT;
  logic [15:0] mem_addr, mem_wdata, writeRegData_OUT, memDataOut_OUT;
  logic [2:0]  writeRegSel_OUT;

  int chkCnt = 0;
  int errCnt = 0;

  mem_stage_ctrl #(.TIMEOUT(4), .ALIGN_CHECK(1)) dut (
    .clk              (clk),
    .rst              (rst),
    .valid_IN         (valid_IN),
    .memRead_IN       (memRead_IN),
    .memWrite_IN      (memWrite_IN),
    .addr_IN          (addr_IN),
    .storeData_IN     (storeData_IN),
    .writeEn_IN       (writeEn_IN),
    .writeRegSel_IN   (writeRegSel_IN),
    .HaltSel_IN       (HaltSel_IN),
    .mem_ready        (mem_ready),
    .mem_done         (mem_done),
    .mem_rdata        (mem_rdata),
    .mem_req          (mem_req),
    .mem_wr           (mem_wr),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .stall_OUT        (stall_OUT),
    .writeEn_OUT      (writeEn_OUT),
    .memRead_OUT      (memRead_OUT),
    .writeRegSel_OUT  (writeRegSel_OUT),
    .writeRegData_OUT (writeRegData_OUT),
    .memDataOut_OUT   (memDataOut_OUT),
    .HaltSel_OUT      (HaltSel_OUT),
    .err_OUT          (err_OUT)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setIn(input logic v, input logic rd, input logic wr, input logic [15:0] a,
                       input logic [15:0] sd, input logic wen, input logic [2:0] sel, input logic h);
    valid_IN = v; memRead_IN = rd; memWrite_IN = wr; addr_IN = a;
    storeData_IN = sd; writeEn_IN = wen; writeRegSel_IN = sel; HaltSel_IN = h;
  endtask

  task automatic doReset();
    rst = 1'b1;
    setIn(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 1'b0);
    mem_ready = 1'b0; mem_done = 1'b0; mem_rdata = 16'h0;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    mem_ready = 1'b0; mem_done = 1'b0; mem_rdata = 16'h0;
    setIn(1'b1, 1'b1, 1'b0, 16'h0040, 16'h0, 1'b1, 3'd1, 1'b1);
    #3;
    checkVal("rst_req",   32'(mem_req),     32'd0);
    checkVal("rst_stall", 32'(stall_OUT),   32'd0);
    checkVal("rst_wen",   32'(writeEn_OUT), 32'd0);
    checkVal("rst_halt",  32'(HaltSel_OUT), 32'd0);
    checkVal("rst_err",   32'(err_OUT),     32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Plain ALU op and halt pass straight through
    setIn(1'b1, 1'b0, 1'b0, 16'h1234, 16'h0, 1'b1, 3'd5, 1'b0);
    #2;
    checkVal("alu_wen",   32'(writeEn_OUT),      32'd1);
    checkVal("alu_sel",   32'(writeRegSel_OUT),  32'd5);
    checkVal("alu_data",  32'(writeRegData_OUT), 32'h1234);
    checkVal("alu_stall", 32'(stall_OUT),        32'd0);
    checkVal("alu_req",   32'(mem_req),          32'd0);
    checkVal("alu_mrd",   32'(memRead_OUT),      32'd0);
    tick();
    setIn(1'b1, 1'b0, 1'b0, 16'h0002, 16'h0, 1'b0, 3'd0, 1'b1);
    #2;
    checkVal("halt_pass", 32'(HaltSel_OUT), 32'd1);

    // Load, ready immediately, done one cycle later
    tick();
    setIn(1'b1, 1'b1, 1'b0, 16'h0040, 16'h0, 1'b1, 3'd3, 1'b0);
    mem_ready = 1'b1;
    #2;
    checkVal("ld_req",   32'(mem_req),     32'd1);
    checkVal("ld_wr",    32'(mem_wr),      32'd0);
    checkVal("ld_addr",  32'(mem_addr),    32'h0040);
    checkVal("ld_stall0",32'(stall_OUT),   32'd1);
    checkVal("ld_bub0",  32'(writeEn_OUT), 32'd0);
    tick();
    mem_ready = 1'b0; mem_done = 1'b1; mem_rdata = 16'hBEEF;
    #2;
    checkVal("ld_wait_req", 32'(mem_req),   32'd0);
    checkVal("ld_stall1",   32'(stall_OUT), 32'd1);
    checkVal("ld_bub1",     32'(writeEn_OUT), 32'd0);
    tick();
    mem_done = 1'b0; mem_rdata = 16'h0;
    #2;
    checkVal("ld_done_stall", 32'(stall_OUT),        32'd0);
    checkVal("ld_done_mrd",   32'(memRead_OUT),      32'd1);
    checkVal("ld_done_data",  32'(memDataOut_OUT),   32'hBEEF);
    checkVal("ld_done_wen",   32'(writeEn_OUT),      32'd1);
    checkVal("ld_done_sel",   32'(writeRegSel_OUT),  32'd3);
    checkVal("ld_done_addr",  32'(writeRegData_OUT), 32'h0040);
    tick();
    setIn(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 1'b0);
    #2;
    checkVal("ld_after_req",   32'(mem_req),   32'd0);
    checkVal("ld_after_stall", 32'(stall_OUT), 32'd0);

    // Store with ready delayed three cycles; done lands on the expiry cycle
    tick();
    setIn(1'b1, 1'b0, 1'b1, 16'h0010, 16'hA5A5, 1'b0, 3'd2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ready = 1'b1;
      #2;
      checkVal("st_req",   32'(mem_req),     32'd1);
      checkVal("st_wr",    32'(mem_wr),      32'd1);
      checkVal("st_addr",  32'(mem_addr),    32'h0010);
      checkVal("st_wdata", 32'(mem_wdata),   32'hA5A5);
      checkVal("st_stall", 32'(stall_OUT),   32'd1);
      checkVal("st_bub",   32'(writeEn_OUT), 32'd0);
      tick();
    end
    mem_ready = 1'b0; mem_done = 1'b1; mem_rdata = 16'h1111;
    #2;
    checkVal("st_wait_req",   32'(mem_req),   32'd0);
    checkVal("st_wait_stall", 32'(stall_OUT), 32'd1);
    tick();
    mem_done = 1'b0; mem_rdata = 16'h0;
    #2;
    checkVal("st_done_stall", 32'(stall_OUT),      32'd0);
    checkVal("st_done_wen",   32'(writeEn_OUT),    32'd0);
    checkVal("st_done_mrd",   32'(memRead_OUT),    32'd0);
    checkVal("st_done_hold",  32'(memDataOut_OUT), 32'hBEEF);
    checkVal("st_done_err",   32'(err_OUT),        32'd0);
    tick();
    setIn(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 1'b0);

    // Load that never completes: ERR after four cycles in REQ+WAIT
    tick();
    setIn(1'b1, 1'b1, 1'b0, 16'h0080, 16'h0, 1'b1, 3'd4, 1'b0);
    mem_ready = 1'b1;
    #2;
    checkVal("to_req", 32'(mem_req), 32'd1);
    tick();
    mem_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #2;
      checkVal("to_wait_stall", 32'(stall_OUT), 32'd1);
      checkVal("to_wait_err",   32'(err_OUT),   32'd0);
      tick();
    end
    #2;
    checkVal("to_err",   32'(err_OUT),     32'd1);
    checkVal("to_stall", 32'(stall_OUT),   32'd1);
    checkVal("to_halt",  32'(HaltSel_OUT), 32'd1);
    checkVal("to_req0",  32'(mem_req),     32'd0);
    checkVal("to_wen",   32'(writeEn_OUT), 32'd0);
    tick();
    doReset();

    // Same load, mem_done on the expiry cycle wins
    tick();
    setIn(1'b1, 1'b1, 1'b0, 16'h0082, 16'h0, 1'b1, 3'd6, 1'b0);
    mem_ready = 1'b1;
    #2;
    tick();
    mem_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      #2;
      checkVal("tw_wait_err", 32'(err_OUT), 32'd0);
      tick();
    end
    mem_done = 1'b1; mem_rdata = 16'hCAFE;
    #2;
    checkVal("tw_exp_stall", 32'(stall_OUT), 32'd1);
    tick();
    mem_done = 1'b0; mem_rdata = 16'h0;
    #2;
    checkVal("tw_done_err",   32'(err_OUT),        32'd0);
    checkVal("tw_done_stall", 32'(stall_OUT),      32'd0);
    checkVal("tw_done_mrd",   32'(memRead_OUT),    32'd1);
    checkVal("tw_done_data",  32'(memDataOut_OUT), 32'hCAFE);
    tick();
    setIn(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 1'b0);

    // Unaligned load goes to sticky ERR without a request
    tick();
    setIn(1'b1, 1'b1, 1'b0, 16'h0041, 16'h0, 1'b1, 3'd1, 1'b0);
    mem_ready = 1'b1;
    #2;
    checkVal("ua_req",   32'(mem_req),   32'd0);
    checkVal("ua_stall", 32'(stall_OUT), 32'd1);
    tick();
    mem_ready = 1'b0;
    #2;
    checkVal("ua_err",   32'(err_OUT),     32'd1);
    checkVal("ua_halt",  32'(HaltSel_OUT), 32'd1);
    checkVal("ua_stall1",32'(stall_OUT),   32'd1);
    checkVal("ua_wen",   32'(writeEn_OUT), 32'd0);
    setIn(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 1'b0);
    tick();
    tick();
    #2;
    checkVal("ua_sticky_err",   32'(err_OUT),   32'd1);
    checkVal("ua_sticky_stall", 32'(stall_OUT), 32'd1);
    checkVal("ua_sticky_req",   32'(mem_req),   32'd0);
    tick();
    doReset();
    #1;
    checkVal("ua_cleared", 32'(err_OUT), 32'd0);

    // Reset asserted mid-WAIT, then a fresh load completes
    tick();
    setIn(1'b1, 1'b1, 1'b0, 16'h0100, 16'h0, 1'b1, 3'd7, 1'b0);
    mem_ready = 1'b1;
    #2;
    tick();
    mem_ready = 1'b0;
    #2;
    checkVal("mr_wait_stall", 32'(stall_OUT), 32'd1);
    rst = 1'b1;
    #1;
    checkVal("mr_req",   32'(mem_req),   32'd0);
    checkVal("mr_stall", 32'(stall_OUT), 32'd0);
    checkVal("mr_err",   32'(err_OUT),   32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    mem_ready = 1'b1;
    #2;
    checkVal("mr_new_req",  32'(mem_req),  32'd1);
    checkVal("mr_new_addr", 32'(mem_addr), 32'h0100);
    tick();
    mem_ready = 1'b0; mem_done = 1'b1; mem_rdata = 16'h5A5A;
    #2;
    tick();
    mem_done = 1'b0; mem_rdata = 16'h0;
    #2;
    checkVal("mr_done_stall", 32'(stall_OUT),       32'd0);
    checkVal("mr_done_mrd",   32'(memRead_OUT),     32'd1);
    checkVal("mr_done_data",  32'(memDataOut_OUT),  32'h5A5A);
    checkVal("mr_done_sel",   32'(writeRegSel_OUT), 32'd7);
    tick();
    setIn(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 1'b0);
    #2;

    $display("End of test - %0d assertions evaluated, %0d failures", chkCnt, errCnt);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Memory-stage sequencer between the X/M pipeline registers and the M/W pipeline registers.
- Drives a multi-cycle data-memory request/ready/done interface and stalls upstream stages while an access is outstanding.
- Inserts bubbles into M/W during stalls and presents load data, ALU result, write-back controls and halt to M/W.
- Flags unaligned accesses and memory timeouts as a sticky error that halts the core.

Parameters:
- TIMEOUT, 64: maximum cycles spent in REQ+WAIT before a timeout error; legal range 2..255.
- ALIGN_CHECK, 1: when 1, a memory op with addr[0]=1 is an error; when 0, no alignment check.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- valid_IN  in  1  X/M holds a real instruction
- memRead_IN  in  1  load
- memWrite_IN  in  1  store
- addr_IN  in  16  effective address (ALU result)
- storeData_IN  in  16  store data
- writeEn_IN  in  1  register write enable
- writeRegSel_IN  in  3  destination register
- HaltSel_IN  in  1  halt instruction
- mem_ready  in  1  memory accepts the request this cycle
- mem_done  in  1  access complete; mem_rdata valid
- mem_rdata  in  16  load data
- mem_req  out  1  request strobe
- mem_wr  out  1  1 = write, 0 = read
- mem_addr  out  16  request address
- mem_wdata  out  16  request write data
- stall_OUT  out  1  freeze PC, F/D, D/X, X/M
- writeEn_OUT  out  1  to M/W
- memRead_OUT  out  1  to M/W
- writeRegSel_OUT  out  3  to M/W
- writeRegData_OUT  out  16  to M/W (addr_IN passthrough)
- memDataOut_OUT  out  16  to M/W (captured load data)
- HaltSel_OUT  out  1  to M/W
- err_OUT  out  1  sticky error flag

Behaviour:
- memop = valid_IN & (memRead_IN | memWrite_IN).
- misalign = ALIGN_CHECK & addr_IN[0].
- FSM states: IDLE, REQ, WAIT, DONE, ERR. Reset value is IDLE.
- Async reset: state=IDLE, timeout counter=0, data hold register=0. All outputs go low immediately, including mem_req.
- IDLE, no memop: pass-through in the same cycle.
  - writeEn_OUT = valid_IN & writeEn_IN; HaltSel_OUT = valid_IN & HaltSel_IN.
  - stall_OUT = 0; memRead_OUT = 0.
- IDLE, memop & misalign: go to ERR; no mem_req is issued.
- IDLE, memop & !misalign:
  - mem_req=1 combinationally; mem_wr=memWrite_IN; mem_addr=addr_IN; mem_wdata=storeData_IN.
  - If mem_ready, go to WAIT; otherwise go to REQ.
- REQ: hold mem_req=1 with the same fields (X/M is frozen). On mem_ready, go to WAIT.
- WAIT: mem_req=0. On mem_done, capture mem_rdata into the hold register and go to DONE.
- DONE:
  - stall_OUT=0; M/W outputs valid; memRead_OUT=memRead_IN; memDataOut_OUT=hold register.
  - Go to IDLE next cycle.
- Minimum memop latency is 3 cycles, with stall_OUT high for 2 of them.
- stall_OUT=1 whenever memop is true and state is not DONE, and always in ERR.
- While stalled, M/W outputs are a bubble: writeEn_OUT=0, memRead_OUT=0, HaltSel_OUT=0.
- Timeout counter:
  - Clears on entering REQ/WAIT from IDLE; increments each cycle in REQ or WAIT.
  - Reaching TIMEOUT-1 without the state-advancing event goes to ERR. If mem_done and the expiry occur in the same cycle, mem_done wins.
- ERR is sticky until rst: stall_OUT=1, err_OUT=1, HaltSel_OUT=1, writeEn_OUT=0, mem_req=0.
- Stores complete in DONE with writeEn_OUT = valid_IN & writeEn_IN (normally 0). mem_rdata is ignored for stores; the hold register is not updated.
- mem_done observed in REQ or IDLE is ignored.
- Outputs in DONE use the X/M values still held; X/M may advance after DONE.

Decomposition:
- Shared package (pipeline_pkg): state encoding constants (IDLE=0, REQ=1, WAIT=2, DONE=3, ERR=4, 3 bits) and the REG_SEL_W=3 and DATA_W=16 constants.
- One natural sub-module, mem_timeout_cnt: an 8-bit clear/increment counter with an expiry compare at TIMEOUT-1, asynchronous reset.

Test Plan:
- Non-mem ALU op: valid=1, writeEn=1, sel=5, addr=0x1234 → same cycle writeEn_OUT=1, writeRegSel_OUT=5, writeRegData_OUT=0x1234, stall_OUT=0, mem_req=0.
- Load at addr 0x0040, mem_ready=1 immediately, mem_done one cycle later with rdata 0xBEEF:
  - Expected: stall 2 cycles, then DONE with memRead_OUT=1 and memDataOut_OUT=0xBEEF.
- Store at 0x0010 with data 0xA5A5, mem_ready delayed 3 cycles:
  - Expected: mem_req held 4 cycles with wr=1, addr=0x0010, wdata=0xA5A5; bubbles emitted; no write-back.
- Unaligned load at addr 0x0041 → no mem_req; next cycle err_OUT=1, HaltSel_OUT=1, stall_OUT=1; state persists until rst.
- TIMEOUT=4, load with mem_done never asserted → ERR exactly 4 cycles after IDLE; a variant with mem_done on the expiry cycle reaches DONE instead.
- rst asserted mid-WAIT → mem_req, stall_OUT and err_OUT go low immediately; after release, a fresh load completes normally.
